// File: rtl/pc_fetch_ctrl.sv
// PC owner and IF-stage driver: sequential fetch, hazard stall, EX redirect with
// IF/ID + ID/EX flush, and a halt on a word-misaligned redirect target.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic [2:0]       i_npc_op,
  input  logic             i_zero,
  input  logic [31:0]      i_npc,
  input  logic             i_imem_ack,
  output logic             o_imem_req,
  output logic [31:0]      o_imem_addr,
  output logic [31:0]      o_pc,
  output logic             o_if_valid,
  output logic             o_flush_ifid,
  output logic             o_flush_idex,
  output logic             o_misalign_err,
  output logic [CNT_W-1:0] o_redirect_cnt
);

  // Next-PC op encodings shared with the control decoder.
  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic        w_fetch;
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_misalign;

  assign w_fetch    = (r_state == S_FETCH);
  assign w_redirect = ((i_npc_op == NPC_BRANCH) & i_zero) |
                      (i_npc_op == NPC_JUMP) | (i_npc_op == NPC_JALR);
  // Bit 0 always cleared (JALR semantics); bit 1 set means not word-aligned.
  assign w_target   = i_npc & ~32'd1;
  assign w_misalign = w_target[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_BOOT: r_state <= S_FETCH;
        S_FETCH: begin
          if (w_redirect) begin
            if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
            if (w_misalign) begin
              r_pc    <= {w_target[31:2], 2'b00};
              r_err   <= 1'b1;
              r_state <= S_HALT;
            end else begin
              r_pc <= w_target;
            end
          end else if (!i_stall && i_imem_ack) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign o_imem_req     = w_fetch;
  assign o_imem_addr    = r_pc;
  assign o_pc           = r_pc;
  assign o_if_valid     = w_fetch & i_imem_ack & ~i_stall & ~w_redirect;
  assign o_flush_ifid   = w_fetch & w_redirect;
  assign o_flush_idex   = w_fetch & w_redirect;
  assign o_misalign_err = r_err;
  assign o_redirect_cnt = r_cnt;

  // PLUS4 is the default non-redirect op; named here so the encoding table is complete.
  logic w_unused_plus4;
  assign w_unused_plus4 = (i_npc_op == NPC_PLUS4);

endmodule
